// File: rtl/prbs5_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prbs5_pkg
//  Description : Shared types and constants for the PRBS-5 checker slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package prbs5_pkg;

    // Checker synchronisation states; encoding is exposed on the debug port.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Feedback taps into the history register (hist[0] is the newest bit).
    localparam int TAP_A    = 1;
    localparam int TAP_B    = 4;
    localparam int LFSR_LEN = 5;

    // Number of received bits needed before the history is meaningful.
    localparam logic [2:0] FILL_TGT = 3'd5;

endpackage : prbs5_pkg
`default_nettype wire

// File: rtl/prbs5_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : prbs5_checker_if
//  Description : Serial input and status bundle for the PRBS-5 checker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prbs5_checker_if
    import prbs5_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic             in_bit;
    logic             in_valid;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] bit_cnt;
    state_t           state;

    // Stream source / status observer side.
    modport master (
        output in_bit,
        output in_valid,
        output clr_cnt,
        input  locked,
        input  err_pulse,
        input  err_cnt,
        input  bit_cnt,
        input  state
    );

    // Checker side.
    modport slave (
        input  in_bit,
        input  in_valid,
        input  clr_cnt,
        output locked,
        output err_pulse,
        output err_cnt,
        output bit_cnt,
        output state
    );

endinterface : prbs5_checker_if
`default_nettype wire

// File: rtl/prbs_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_sat_cnt
//  Description : Saturating up-counter with synchronous clear (clear wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             inc,
    input  wire logic             clr,
    output logic      [CNT_W-1:0] cnt
);

    // Count up on inc, stick at all-ones, clear takes priority over inc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule : prbs_sat_cnt
`default_nettype wire

// File: rtl/prbs5_checker.sv
`default_nettype none
// ============================================================================
//  Module      : prbs5_checker
//  Description : Self-synchronising checker for x[n] = x[n-2] ^ x[n-5].
//                Hunts for a non-zero history, verifies SYNC_LEN correct
//                predictions, then flywheels on its own prediction while
//                counting bit errors and watching for loss of lock.
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs5_checker
    import prbs5_pkg::*;
#(
    parameter int SYNC_LEN = 8,
    parameter int LOSS_THR = 3,
    parameter int CNT_W    = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    prbs5_checker_if.slave    bus
);

    localparam logic [7:0] SYNC_LEN_C = 8'(SYNC_LEN);
    localparam logic [3:0] LOSS_THR_C = 4'(LOSS_THR);

    state_t                state_r;
    logic [LFSR_LEN-1:0]   hist_r;
    logic [2:0]            fill_r;
    logic [7:0]            match_r;
    logic [3:0]            err_run_r;
    logic                  locked_r;
    logic                  err_pulse_r;

    state_t                state_n;
    logic [LFSR_LEN-1:0]   hist_n;
    logic [2:0]            fill_n;
    logic [7:0]            match_n;
    logic [3:0]            err_run_n;
    logic                  pulse_n;

    logic                  pred;
    logic                  miss;
    logic [LFSR_LEN-1:0]   shift_rx;
    logic [LFSR_LEN-1:0]   shift_pred;
    logic                  err_inc;
    logic                  bit_inc;

    // Prediction, shifted-history candidates and next-state decisions.
    always_comb begin
        pred       = hist_r[TAP_A] ^ hist_r[TAP_B];
        miss       = bus.in_bit ^ pred;
        shift_rx   = {hist_r[LFSR_LEN-2:0], bus.in_bit};
        shift_pred = {hist_r[LFSR_LEN-2:0], pred};

        state_n    = state_r;
        hist_n     = hist_r;
        fill_n     = fill_r;
        match_n    = match_r;
        err_run_n  = err_run_r;
        pulse_n    = 1'b0;

        if (bus.in_valid) begin
            unique case (state_r)
                HUNT: begin
                    hist_n = shift_rx;
                    fill_n = (fill_r == FILL_TGT) ? fill_r : fill_r + 3'd1;
                    // An all-zero history is a fixed point of the recurrence,
                    // so it can never be used as a starting point.
                    if ((fill_n == FILL_TGT) && (shift_rx != '0)) begin
                        state_n = VERIFY;
                        match_n = '0;
                    end
                end
                VERIFY: begin
                    hist_n = shift_rx;
                    if (shift_rx == '0) begin
                        state_n = HUNT;
                        fill_n  = FILL_TGT;
                        match_n = '0;
                    end else if (!miss) begin
                        if ((match_r + 8'd1) == SYNC_LEN_C) begin
                            state_n   = LOCKED;
                            match_n   = '0;
                            err_run_n = '0;
                        end else begin
                            match_n = match_r + 8'd1;
                        end
                    end else begin
                        match_n = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the history follows the prediction, so a
                    // corrupted line bit never pollutes later predictions.
                    hist_n  = shift_pred;
                    pulse_n = miss;
                    if (!miss) begin
                        err_run_n = '0;
                    end else if ((err_run_r + 4'd1) == LOSS_THR_C) begin
                        state_n   = HUNT;
                        fill_n    = '0;
                        err_run_n = '0;
                    end else begin
                        err_run_n = err_run_r + 4'd1;
                    end
                end
                default: begin
                    state_n = HUNT;
                    fill_n  = '0;
                end
            endcase
        end
    end

    // Synchronisation state, history and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= HUNT;
            hist_r      <= '0;
            fill_r      <= '0;
            match_r     <= '0;
            err_run_r   <= '0;
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            hist_r      <= hist_n;
            fill_r      <= fill_n;
            match_r     <= match_n;
            err_run_r   <= err_run_n;
            locked_r    <= (state_n == LOCKED);
            err_pulse_r <= pulse_n;
        end
    end

    assign err_inc = bus.in_valid && (state_r == LOCKED) && miss;
    assign bit_inc = bus.in_valid && (state_r == LOCKED);

    prbs_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .clr   (bus.clr_cnt),
        .cnt   (bus.err_cnt)
    );

    prbs_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bit_inc),
        .clr   (bus.clr_cnt),
        .cnt   (bus.bit_cnt)
    );

    assign bus.state     = state_r;
    assign bus.locked    = locked_r;
    assign bus.err_pulse = err_pulse_r;

endmodule : prbs5_checker
`default_nettype wire
